// File: rtl/mem_stall_if.sv
// mem_stall_if
//  Request/response bundle between a MEM-stage requester and the multi-cycle
//  data memory (mem_stall).
//  Signals:
//   enable    requester -> memory  access request, held with wr/addr/data_in until done
//   wr        requester -> memory  1 = write, 0 = read
//   addr      requester -> memory  byte address
//   data_in   requester -> memory  write data
//   data_out  memory -> requester  read data, nonzero only in the done cycle
//   stall     memory -> requester  enable & ~done, used by the hazard unit to freeze the pipe
//   done      memory -> requester  one-cycle completion pulse
//   err       memory -> requester  with done: access was misaligned or out of range
//  Modports: master = requester side, slave = memory side.
interface mem_stall_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  enable;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  stall;
    logic                  done;
    logic                  err;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, stall, done, err
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, stall, done, err
    );
endinterface

// File: rtl/mem_stall.sv
// mem_stall
//  Multi-cycle data memory for the MEM stage. An access is accepted from IDLE
//  on a rising edge with enable=1, runs for LATENCY cycles and finishes with a
//  single DONE cycle in which done pulses (plus err / read data). Misaligned or
//  out-of-range accesses take the same time, raise err and never write.
//  Ports:
//   clk   clock, all state changes on the rising edge
//   rst   synchronous active-high reset; aborts any access in flight
//   bus   mem_stall_if.slave (enable, wr, addr, data_in / data_out, stall, done, err)
module mem_stall #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_stall_if.slave   bus
);
    // Byte-offset bits inside one word, and the first address bit above the word index.
    localparam int OFS    = $clog2(DATA_WIDTH / 8);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int IDX_HI = OFS + DEPTH_LOG2;
    localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;

    // Request captured at acceptance; BUSY works only from these.
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // The access being completed. With LATENCY=1 the edge that accepts is also
    // the edge that enters DONE, so in IDLE the live inputs stand in for the
    // (not yet captured) registers.
    logic                    acc_wr;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    bad_access;
    logic                    accept;
    logic                    finish;

    assign acc_wr     = (state_q == S_IDLE) ? bus.wr      : wr_q;
    assign acc_addr   = (state_q == S_IDLE) ? bus.addr    : addr_q;
    assign acc_wdata  = (state_q == S_IDLE) ? bus.data_in : wdata_q;
    assign acc_idx    = DEPTH_LOG2'(acc_addr >> OFS);
    assign misaligned = |acc_addr[OFS-1:0];

    // Any address bit above the index field set means the word is beyond DEPTH.
    generate
        if (IDX_HI < ADDR_WIDTH) begin : g_range
            assign out_of_range = |acc_addr[ADDR_WIDTH-1:IDX_HI];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign bad_access = misaligned | out_of_range;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = S_DONE;
                        finish  = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                        count_d = CW'(LATENCY - 1);
                    end
                end
            end
            S_BUSY: begin
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                end
            end
            S_DONE: begin
                // Exactly one cycle; enable still high here is not a new request.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, capture and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept) begin
                wr_q    <= bus.wr;
                addr_q  <= bus.addr;
                wdata_q <= bus.data_in;
            end
            err_q <= finish & bad_access;
            // Registered read; cleared outside the DONE cycle and for writes/errors.
            if (finish && !acc_wr && !bad_access) begin
                rdata_q <= mem[acc_idx];
            end else begin
                rdata_q <= '0;
            end
        end
    end

    // Storage is never cleared. The write lands on the edge that enters DONE,
    // so a reset on that edge (or earlier) drops it.
    always_ff @(posedge clk) begin
        if (!rst && finish && acc_wr && !bad_access) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.done     = (state_q == S_DONE);
    assign bus.err      = err_q;
    assign bus.data_out = rdata_q;
    assign bus.stall    = bus.enable & ~bus.done;

endmodule

// File: tb/tb_mem_stall.sv
// tb_mem_stall
//  Bench for mem_stall: a LATENCY=4, 16-word instance exercised with directed
//  and random accesses against a word-array model, plus a LATENCY=1 instance
//  driven with enable held high.
module tb_mem_stall;
    localparam int LAT   = 4;
    localparam int WORDS = 16;

    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    logic [15:0] ref_mem [WORDS];

    mem_stall_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) m_if ();
    mem_stall_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) l1_if ();

    mem_stall #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_LOG2(4), .LATENCY(LAT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    mem_stall #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_LOG2(10), .LATENCY(1)
    ) u_dut_l1 (
        .clk (clk),
        .rst (rst),
        .bus (l1_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access on the LATENCY=4 instance. Called and returning at a negedge
    // with the memory idle. abort_at=k (1..LAT-1) asserts rst after the k-th
    // busy sample; scramble changes addr/data_in while the access is busy.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input bit scramble, input int abort_at);
        logic        exp_err;
        logic [15:0] exp_data;
        int          idx;
        exp_err  = (a[0] != 1'b0) || ((a >> 1) >= WORDS);
        idx      = int'(a[4:1]);
        exp_data = (!w && !exp_err) ? ref_mem[idx] : 16'h0000;

        m_if.enable  = 1'b1;
        m_if.wr      = w;
        m_if.addr    = a;
        m_if.data_in = d;
        #1 check_eq("stall_req", m_if.stall, 1);

        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k < LAT) begin
                check_eq("busy_done", m_if.done, 0);
                check_eq("busy_stall", m_if.stall, 1);
                check_eq("busy_data", m_if.data_out, 0);
                if (abort_at == k) begin
                    rst         = 1'b1;
                    m_if.enable = 1'b0;
                    @(negedge clk);
                    check_eq("abort_done", m_if.done, 0);
                    check_eq("abort_stall", m_if.stall, 0);
                    rst = 1'b0;
                    repeat (LAT) begin
                        @(negedge clk);
                        check_eq("abort_nodone", m_if.done, 0);
                    end
                    $display("txn %s addr=%h wdata=%h aborted by reset", w ? "WR" : "RD", a, d);
                    return;
                end
                if (scramble) begin
                    m_if.addr    = 16'($urandom);
                    m_if.data_in = 16'($urandom);
                end
            end else begin
                check_eq("done", m_if.done, 1);
                check_eq("done_stall", m_if.stall, 0);
                check_eq("err", m_if.err, {31'd0, exp_err});
                check_eq("rdata", m_if.data_out, {16'd0, exp_data});
                $display("txn %s addr=%h wdata=%h -> done err=%0d rdata=%h (exp err=%0d rdata=%h)",
                         w ? "WR" : "RD", a, d, m_if.err, m_if.data_out, exp_err, exp_data);
                if (w && !exp_err) ref_mem[idx] = d;
                m_if.enable = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("idle_done", m_if.done, 0);
        check_eq("idle_data", m_if.data_out, 0);
        check_eq("idle_err", m_if.err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic        in_done;
        logic        acc_wr;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        m_if.enable = 1'b0;  m_if.wr = 1'b0;  m_if.addr = '0;  m_if.data_in = '0;
        l1_if.enable = 1'b0; l1_if.wr = 1'b0; l1_if.addr = '0; l1_if.data_in = '0;

        // Reset state, and stall following enable while in reset.
        repeat (3) @(negedge clk);
        check_eq("rst_done", m_if.done, 0);
        check_eq("rst_err", m_if.err, 0);
        check_eq("rst_data", m_if.data_out, 0);
        check_eq("rst_stall", m_if.stall, 0);
        m_if.enable = 1'b1;
        #1 check_eq("rst_stall_en", m_if.stall, 1);
        @(negedge clk);
        check_eq("rst_hold_done", m_if.done, 0);
        m_if.enable = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_done", m_if.done, 0);

        // Give every word a known value.
        for (int i = 0; i < WORDS; i++) access(1'b1, 16'(i * 2), 16'($urandom), 1'b0, 0);

        // Write then read back.
        access(1'b1, 16'h0010, 16'hBEEF, 1'b0, 0);
        access(1'b0, 16'h0010, 16'h0000, 1'b0, 0);
        // Misaligned read and write: error, word 8 untouched.
        access(1'b0, 16'h0011, 16'h0000, 1'b0, 0);
        access(1'b1, 16'h0011, 16'hDEAD, 1'b0, 0);
        access(1'b0, 16'h0010, 16'h0000, 1'b0, 0);
        // Range boundary: index 16 rejected, index 15 accepted.
        access(1'b0, 16'h0020, 16'h0000, 1'b0, 0);
        access(1'b1, 16'h0020, 16'h1111, 1'b0, 0);
        access(1'b1, 16'h001E, 16'h7777, 1'b0, 0);
        access(1'b0, 16'h001E, 16'h0000, 1'b0, 0);
        access(1'b0, 16'h8000, 16'h0000, 1'b0, 0);
        // Reset during a write: nothing committed.
        access(1'b1, 16'h0004, 16'h1234, 1'b0, 2);
        access(1'b0, 16'h0004, 16'h0000, 1'b0, 0);
        // Inputs changed while busy are ignored.
        access(1'b1, 16'h000C, 16'hCAFE, 1'b1, 0);
        access(1'b0, 16'h000C, 16'h0000, 1'b1, 0);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            access(1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, LAT - 1)) : 0);
        end

        // LATENCY=1 instance with enable held high: a write then back-to-back
        // reads of the same word, one completion every second cycle.
        l1_if.enable  = 1'b1;
        l1_if.wr      = 1'b1;
        l1_if.addr    = 16'h0002;
        l1_if.data_in = 16'h5A5A;
        in_done = 1'b0;
        acc_wr  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (!in_done && l1_if.enable) begin
                in_done = 1'b1;
                acc_wr  = l1_if.wr;
            end else begin
                in_done = 1'b0;
            end
            @(negedge clk);
            check_eq("l1_done", l1_if.done, {31'd0, in_done});
            check_eq("l1_stall", l1_if.stall, {31'd0, l1_if.enable & ~in_done});
            check_eq("l1_err", l1_if.err, 0);
            check_eq("l1_data", l1_if.data_out, (in_done && !acc_wr) ? 32'h5A5A : 32'h0);
            if (in_done) begin
                $display("txn L1 %s addr=0002 -> done rdata=%h", acc_wr ? "WR" : "RD", l1_if.data_out);
                l1_if.wr = 1'b0;
            end
        end
        l1_if.enable = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
